// File: rtl/led_checker_pkg.sv
// Shared types and constants for the LED half-period checker.
package led_checker_pkg;

  localparam int unsigned PERIOD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    FINISH
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/led_period_checker.sv
// Measures consecutive LED half-periods against CLK_FREQ_HZ +/- TOL_CYCLES.
// Optional watchdog on a missing edge: define LED_PERIOD_CHECKER_TIMEOUT_EN.
module led_period_checker
  import led_checker_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000,
  parameter int unsigned PULSES      = 5,
  parameter int unsigned TOL_CYCLES  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_i,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          ok_count,
  output logic [PERIOD_W-1:0] last_period
);

  localparam longint LO_RAW = longint'(CLK_FREQ_HZ) - longint'(TOL_CYCLES);
  localparam logic [63:0] LO_W = (LO_RAW < 1) ? 64'd1 : 64'(LO_RAW);
  localparam logic [63:0] HI_W = 64'(CLK_FREQ_HZ) + 64'(TOL_CYCLES);

  state_e                state_q, state_d;
  logic [PERIOD_W-1:0]   counter_q, counter_d;
  logic [PERIOD_W-1:0]   last_q, last_d;
  logic [7:0]            ok_q, ok_d;
  logic                  pass_q, pass_d;
  logic                  led_s, led_prev_q, strobe_q;
  logic [PERIOD_W-1:0]   counter_inc;
  logic [7:0]            ok_next;
  logic                  in_range;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (led_i),
    .q_o   (led_s)
  );

  // Registered edge strobe keeps rise and fall latency identical (3 clk).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_prev_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      led_prev_q <= led_s;
      strobe_q   <= led_s ^ led_prev_q;
    end
  end

  assign counter_inc = (&counter_q) ? counter_q : counter_q + 1'b1;
  assign ok_next     = ok_q + 8'd1;
  assign in_range    = (64'(counter_q) >= LO_W) && (64'(counter_q) <= HI_W);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    last_d    = last_q;
    ok_d      = ok_q;
    pass_d    = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ARM;
          counter_d = '0;
          last_d    = '0;
          ok_d      = '0;
          pass_d    = 1'b0;
        end
      end
      ARM: begin
        if (strobe_q) begin
          state_d   = MEASURE;
          counter_d = PERIOD_W'(1);
        end
      end
      MEASURE: begin
        if (strobe_q) begin
          last_d    = counter_q;
          counter_d = PERIOD_W'(1);
          if (in_range) begin
            ok_d = ok_next;
            if (ok_next == 8'(PULSES)) begin
              state_d = FINISH;
              pass_d  = 1'b1;
            end
          end else begin
            state_d = FINISH;
            pass_d  = 1'b0;
          end
        end else begin
          counter_d = counter_inc;
`ifdef LED_PERIOD_CHECKER_TIMEOUT_EN
          if (64'(counter_q) > HI_W) begin
            state_d = FINISH;
            pass_d  = 1'b0;
            last_d  = counter_q;
          end
`endif
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      last_q    <= '0;
      ok_q      <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      last_q    <= last_d;
      ok_q      <= ok_d;
      pass_q    <= pass_d;
    end
  end

  assign busy        = (state_q == ARM) || (state_q == MEASURE);
  assign done        = (state_q == FINISH);
  assign pass        = pass_q;
  assign ok_count    = ok_q;
  assign last_period = last_q;

endmodule

// File: tb/tb_led_period_checker.sv
// Directed bench: dut0 (TOL 0) and dut1 (TOL 2), both CLK_FREQ_HZ=1000, PULSES=5.
module tb_led_period_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        led_v   [2];
  logic        start_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        pass_v  [2];
  logic [7:0]  ok_v    [2];
  logic [31:0] last_v  [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_period_checker #(.CLK_FREQ_HZ(1000), .PULSES(5), .TOL_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .led_i(led_v[0]), .start(start_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .ok_count(ok_v[0]), .last_period(last_v[0])
  );

  led_period_checker #(.CLK_FREQ_HZ(1000), .PULSES(5), .TOL_CYCLES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .led_i(led_v[1]), .start(start_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .ok_count(ok_v[1]), .last_period(last_v[1])
  );

  typedef struct {
    int sel;
    int n;
    int gaps [5];
    int exp_pass;
    int exp_ok;
    int exp_last;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int s);
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    check("busy_after_start", busy_v[s], 1);
    check("ok_cleared", ok_v[s], 0);
    check("last_cleared", last_v[s], 0);
    check("pass_cleared", pass_v[s], 0);
  endtask

  task automatic toggle_after(input int s, input int g);
    repeat (g) tick();
    led_v[s] = ~led_v[s];
  endtask

  task automatic wait_done(input int s, input int budget, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (done_v[s]) seen = 1'b1;
    end
  endtask

  task automatic check_result(input int s, input int ep, input int eo, input int el);
    check("pass", pass_v[s], ep);
    check("ok_count", ok_v[s], eo);
    check("last_period", last_v[s], el);
    check("busy_low_at_done", busy_v[s], 0);
  endtask

  initial begin
    bit seen;
    int cyc;
    int done_cnt;

    vecs[0] = '{0, 5, '{1000, 1000, 1000, 1000, 1000}, 1, 5, 1000};
    vecs[1] = '{0, 2, '{1000, 999, 0, 0, 0},          0, 1, 999};
    vecs[2] = '{1, 5, '{998, 1002, 1000, 1001, 999},   1, 5, 999};
    vecs[3] = '{1, 1, '{997, 0, 0, 0, 0},              0, 0, 997};
    vecs[4] = '{1, 2, '{1000, 1003, 0, 0, 0},          0, 1, 1003};
    vecs[5] = '{0, 1, '{1001, 0, 0, 0, 0},             0, 0, 1001};
    vecs[6] = '{0, 1, '{1, 0, 0, 0, 0},                0, 0, 1};

    for (int s = 0; s < 2; s++) begin
      led_v[s] = 1'b0;
      start_v[s] = 1'b0;
    end
    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", busy_v[s], 0);
      check("rst_done", done_v[s], 0);
      check("rst_pass", pass_v[s], 0);
      check("rst_ok", ok_v[s], 0);
      check("rst_last", last_v[s], 0);
    end
    rst_n = 1'b1;
    repeat (5) tick();

    // Table-driven runs
    for (int v = 0; v < 7; v++) begin
      start_run(vecs[v].sel);
      toggle_after(vecs[v].sel, 5);
      for (int i = 0; i < vecs[v].n; i++) toggle_after(vecs[v].sel, vecs[v].gaps[i]);
      wait_done(vecs[v].sel, 20, seen, cyc);
      check("done_seen", seen, 1);
      check_result(vecs[v].sel, vecs[v].exp_pass, vecs[v].exp_ok, vecs[v].exp_last);
      tick();
      check("done_one_cycle", done_v[vecs[v].sel], 0);
      repeat (5) tick();
    end

    // LED activity in IDLE leaves the last result (vecs[6]) untouched
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      toggle_after(0, 7);
      if (done_v[0]) done_cnt++;
    end
    repeat (10) tick();
    check("idle_busy", busy_v[0], 0);
    check("idle_done_cnt", done_cnt, 0);
    check_result(0, 0, 0, 1);

    // Start pulses while busy are ignored; start in FINISH is ignored
    start_run(0);
    toggle_after(0, 5);
    for (int i = 0; i < 5; i++) begin
      repeat (500) tick();
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (499) tick();
      led_v[0] = ~led_v[0];
    end
    wait_done(0, 20, seen, cyc);
    check("busy_start_done_seen", seen, 1);
    check_result(0, 1, 5, 1000);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    check("finish_start_busy", busy_v[0], 0);
    tick();
    check("finish_start_busy2", busy_v[0], 0);
    repeat (5) tick();

    // Reset mid-run aborts without done
    start_run(0);
    toggle_after(0, 5);
    toggle_after(0, 1000);
    toggle_after(0, 1000);
    repeat (300) tick();
    check("pre_reset_ok", ok_v[0], 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_v[0], 0);
    check("mid_rst_done", done_v[0], 0);
    check("mid_rst_ok", ok_v[0], 0);
    check("mid_rst_last", last_v[0], 0);
    check("mid_rst_pass", pass_v[0], 0);
    #20 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_v[0]) done_cnt++;
    end
    check("post_rst_no_done", done_cnt, 0);
    check("post_rst_busy", busy_v[0], 0);
    start_run(0);
    toggle_after(0, 5);
    for (int i = 0; i < 5; i++) toggle_after(0, 1000);
    wait_done(0, 20, seen, cyc);
    check("post_rst_done_seen", seen, 1);
    check_result(0, 1, 5, 1000);
    repeat (5) tick();

    // Missing edge after the second edge
    start_run(0);
    toggle_after(0, 5);
    toggle_after(0, 1000);
`ifdef LED_PERIOD_CHECKER_TIMEOUT_EN
    wait_done(0, 1100, seen, cyc);
    check("timeout_done_seen", seen, 1);
    check("timeout_latency_ok", (cyc >= 1000 && cyc <= 1010), 1);
    check_result(0, 0, 1, 1001);
`else
    done_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_v[0]) done_cnt++;
    end
    check("no_timeout_busy", busy_v[0], 1);
    check("no_timeout_done_cnt", done_cnt, 0);
    check("no_timeout_ok", ok_v[0], 1);
    check("no_timeout_last", last_v[0], 1000);
    rst_n = 1'b0;
    #20 rst_n = 1'b1;
`endif
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
